// File: rtl/bus_xbar_rr.sv
// Shared bus: round-robin arbitration of NUM_M masters onto one path, address
// decode to NUM_S slaves, and error completion for unmapped or silent slaves.
module bus_xbar_rr #(
    parameter int NUM_M   = 4,
    parameter int NUM_S   = 8,
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rest,
    input  logic [NUM_M-1:0]         m_req,
    input  logic [NUM_M*ADDR_W-1:0]  m_addr,
    input  logic [NUM_M-1:0]         m_as,
    input  logic [NUM_M-1:0]         m_rw,
    input  logic [NUM_M*DATA_W-1:0]  m_wr_data,
    output logic [NUM_M-1:0]         m_grnt,
    output logic [ADDR_W-1:0]        s_addr,
    output logic                     s_as,
    output logic                     s_rw,
    output logic [DATA_W-1:0]        s_wr_data,
    output logic [NUM_S-1:0]         s_cs,
    input  logic [NUM_S*DATA_W-1:0]  s_rd_data,
    input  logic [NUM_S-1:0]         s_rdy,
    output logic [DATA_W-1:0]        bus_rd_data,
    output logic                     bus_rdy,
    output logic                     bus_err
);
    localparam int OWN_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [OWN_W-1:0]   last_reg, win;
    logic               owner_vld_reg;
    logic [NUM_M-1:0]   grnt_reg, grnt_next;
    logic               found, arb_en;
    logic [SEL_W-1:0]   idx;
    logic               mapped, rdy_hit;

    // Two-pass scan: masters above last first, then wrap to those at or below it.
    always_comb begin
        found     = 1'b0;
        win       = '0;
        grnt_next = '0;
        for (int c = 0; c < NUM_M; c++) begin
            if (!found && m_req[c] && (c > int'(last_reg))) begin
                found        = 1'b1;
                win          = OWN_W'(c);
                grnt_next[c] = 1'b1;
            end
        end
        for (int c = 0; c < NUM_M; c++) begin
            if (!found && m_req[c] && (c <= int'(last_reg))) begin
                found        = 1'b1;
                win          = OWN_W'(c);
                grnt_next[c] = 1'b1;
            end
        end
    end

    // The grant register doubles as the owner index in one-hot form.
    assign arb_en = (!owner_vld_reg || !(|(m_req & grnt_reg))) && (state_reg == IDLE);
    assign m_grnt = grnt_reg;

    always_comb begin
        s_addr    = '0;
        s_wr_data = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (grnt_reg[i]) begin
                s_addr    = s_addr | m_addr[i*ADDR_W +: ADDR_W];
                s_wr_data = s_wr_data | m_wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign s_as = |(grnt_reg & m_as);
    assign s_rw = |(grnt_reg & m_rw);

    assign idx    = s_addr[ADDR_W-1 -: SEL_W];
    assign mapped = ({1'b0, idx} < (SEL_W+1)'(NUM_S));

    for (genvar gi = 0; gi < NUM_S; gi++) begin : g_cs
        assign s_cs[gi] = s_as && mapped && (state_reg != ERR) && (idx == SEL_W'(gi));
    end

    assign rdy_hit = |(s_cs & s_rdy);

    always_comb begin
        bus_rd_data = '0;
        for (int i = 0; i < NUM_S; i++) begin
            if (s_cs[i]) begin
                bus_rd_data = bus_rd_data | s_rd_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bus_rdy    = 1'b0;
        bus_err    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (s_as) begin
                    if (!mapped) begin
                        state_next = ERR;
                    end else if (rdy_hit) begin
                        bus_rdy = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_W'(1);
                    end
                end
            end
            WAIT: begin
                if (rdy_hit) begin
                    bus_rdy    = 1'b1;
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (!s_as) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_W'(TIMEOUT)) begin
                    state_next = ERR;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ERR: begin
                bus_rdy    = 1'b1;
                bus_err    = 1'b1;
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            grnt_reg      <= '0;
            owner_vld_reg <= 1'b0;
            last_reg      <= OWN_W'(NUM_M - 1);
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (arb_en) begin
                grnt_reg      <= grnt_next;
                owner_vld_reg <= found;
                if (found) begin
                    last_reg <= win;
                end
            end
        end
    end
endmodule

// File: tb/tb_bus_xbar_rr.sv
// Directed bench for bus_xbar_rr: arbitration order, decode, wait states,
// unmapped and timeout errors, and reset during a pending transfer.
module tb_bus_xbar_rr;
    localparam int NUM_M   = 4;
    localparam int NUM_S   = 6;
    localparam int ADDR_W  = 30;
    localparam int DATA_W  = 32;
    localparam int SEL_W   = 3;
    localparam int TIMEOUT = 4;

    logic                    clk = 1'b0;
    logic                    rest;
    logic [NUM_M-1:0]        m_req;
    logic [NUM_M*ADDR_W-1:0] m_addr;
    logic [NUM_M-1:0]        m_as;
    logic [NUM_M-1:0]        m_rw;
    logic [NUM_M*DATA_W-1:0] m_wr_data;
    logic [NUM_M-1:0]        m_grnt;
    logic [ADDR_W-1:0]       s_addr;
    logic                    s_as;
    logic                    s_rw;
    logic [DATA_W-1:0]       s_wr_data;
    logic [NUM_S-1:0]        s_cs;
    logic [NUM_S*DATA_W-1:0] s_rd_data;
    logic [NUM_S-1:0]        s_rdy;
    logic [DATA_W-1:0]       bus_rd_data;
    logic                    bus_rdy;
    logic                    bus_err;

    int checks   = 0;
    int failures = 0;

    bus_xbar_rr #(
        .NUM_M(NUM_M), .NUM_S(NUM_S), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .SEL_W(SEL_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rest(rest),
        .m_req(m_req), .m_addr(m_addr), .m_as(m_as), .m_rw(m_rw), .m_wr_data(m_wr_data),
        .m_grnt(m_grnt),
        .s_addr(s_addr), .s_as(s_as), .s_rw(s_rw), .s_wr_data(s_wr_data), .s_cs(s_cs),
        .s_rd_data(s_rd_data), .s_rdy(s_rdy),
        .bus_rd_data(bus_rd_data), .bus_rdy(bus_rdy), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] mk_addr(input int sel);
        logic [31:0] s;
        s = sel;
        return {s[SEL_W-1:0], (ADDR_W-SEL_W)'(12'hab0)};
    endfunction

    task automatic set_m(input int i, input logic req, input logic as, input logic rw,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        m_req[i]                     = req;
        m_as[i]                      = as;
        m_rw[i]                      = rw;
        m_addr[i*ADDR_W +: ADDR_W]   = a;
        m_wr_data[i*DATA_W +: DATA_W] = d;
    endtask

    initial begin
        logic [NUM_M-1:0] exp_g;

        rest = 1'b1; m_req = '0; m_as = '0; m_rw = '0; m_addr = '0; m_wr_data = '0;
        s_rdy = '0;
        for (int i = 0; i < NUM_S; i++) s_rd_data[i*DATA_W +: DATA_W] = 32'hA5A5_0000 + i;
        cyc(); cyc();

        // Post-reset outputs, then m2 read to slave 3 with zero wait states
        rest = 1'b0;
        set_m(2, 1'b1, 1'b1, 1'b1, mk_addr(3), '0);
        s_rdy = 6'h08;
        settle();
        chk("rst_grnt", m_grnt, 0);
        chk("rst_cs", s_cs, 0);
        chk("rst_rdy", bus_rdy, 0);
        chk("rst_err", bus_err, 0);
        chk("rst_addr", s_addr, 0);
        cyc(); settle();
        chk("zw_grnt", m_grnt, 4'b0100);
        chk("zw_cs", s_cs, 6'h08);
        chk("zw_rdy", bus_rdy, 1);
        chk("zw_err", bus_err, 0);
        chk("zw_data", bus_rd_data, 32'hA5A5_0003);
        chk("zw_addr", s_addr, mk_addr(3));
        chk("zw_rw", s_rw, 1);
        cyc();
        set_m(2, 1'b0, 1'b0, 1'b0, '0, '0);
        s_rdy = '0;
        settle();
        chk("zw_hold", m_grnt, 4'b0100);
        chk("zw_rdy_off", bus_rdy, 0);
        cyc(); settle();
        chk("zw_release", m_grnt, 0);

        // Round robin: everyone requests, each owner holds req two cycles after grant
        rest = 1'b1;
        cyc();
        rest = 1'b0;
        m_req = 4'b1111;
        cyc();
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            m_req = 4'b1111;
            settle();
            chk("rr_grant_first", m_grnt, exp_g);
            cyc(); settle();
            chk("rr_grant_second", m_grnt, exp_g);
            cyc();
            m_req = 4'b1111 & ~exp_g;
            settle();
            chk("rr_grant_drop", m_grnt, exp_g);
            cyc();
        end
        m_req = '0;

        // Unmapped slave index 7
        rest = 1'b1;
        cyc();
        rest = 1'b0;
        set_m(0, 1'b1, 1'b1, 1'b1, mk_addr(7), '0);
        s_rdy = 6'h3f;
        cyc(); settle();
        chk("um_grnt", m_grnt, 4'b0001);
        chk("um_cs", s_cs, 0);
        chk("um_rdy_early", bus_rdy, 0);
        chk("um_err_early", bus_err, 0);
        cyc();
        set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
        settle();
        chk("um_rdy", bus_rdy, 1);
        chk("um_err", bus_err, 1);
        chk("um_data", bus_rd_data, 0);
        chk("um_cs_err", s_cs, 0);
        chk("um_grnt_err", m_grnt, 4'b0001);
        cyc(); settle();
        chk("um_idle_err", bus_err, 0);
        chk("um_idle_rdy", bus_rdy, 0);
        chk("um_idle_grnt", m_grnt, 4'b0001);
        cyc(); settle();
        chk("um_release", m_grnt, 0);
        s_rdy = '0;

        // Timeout: slave 2 never answers, m1 drops req mid-wait
        set_m(1, 1'b1, 1'b1, 1'b1, mk_addr(2), '0);
        cyc(); settle();
        chk("to_grnt", m_grnt, 4'b0010);
        chk("to_cs", s_cs, 6'h04);
        chk("to_rdy0", bus_rdy, 0);
        for (int w = 1; w <= TIMEOUT; w++) begin
            cyc();
            if (w == 2) m_req[1] = 1'b0;
            settle();
            chk("to_wait_err", bus_err, 0);
            chk("to_wait_rdy", bus_rdy, 0);
            chk("to_wait_grnt", m_grnt, 4'b0010);
        end
        cyc(); settle();
        chk("to_err", bus_err, 1);
        chk("to_rdy", bus_rdy, 1);
        chk("to_data", bus_rd_data, 0);
        chk("to_grnt_err", m_grnt, 4'b0010);
        m_as[1] = 1'b0;
        cyc(); settle();
        chk("to_idle_err", bus_err, 0);
        chk("to_idle_grnt", m_grnt, 4'b0010);
        cyc(); settle();
        chk("to_release", m_grnt, 0);

        // m0 write to a 3-wait slave 4 while m1 waits for the bus
        set_m(0, 1'b1, 1'b1, 1'b0, mk_addr(4), 32'hDEAD_BEEF);
        cyc();
        set_m(1, 1'b1, 1'b1, 1'b1, mk_addr(5), '0);
        settle();
        chk("ws_grnt", m_grnt, 4'b0001);
        chk("ws_cs", s_cs, 6'h10);
        chk("ws_wdata", s_wr_data, 32'hDEAD_BEEF);
        chk("ws_rw", s_rw, 0);
        chk("ws_rdy0", bus_rdy, 0);
        for (int w = 1; w <= 2; w++) begin
            cyc(); settle();
            chk("ws_wait_rdy", bus_rdy, 0);
            chk("ws_wait_grnt", m_grnt, 4'b0001);
        end
        cyc();
        s_rdy = 6'h10;
        m_req[0] = 1'b0;
        settle();
        chk("ws_rdy", bus_rdy, 1);
        chk("ws_err", bus_err, 0);
        chk("ws_grnt_done", m_grnt, 4'b0001);
        cyc();
        s_rdy = '0;
        m_as[0] = 1'b0;
        settle();
        chk("ws_hold_idle", m_grnt, 4'b0001);
        chk("ws_rdy_off", bus_rdy, 0);
        cyc(); settle();
        chk("ws_m1_grnt", m_grnt, 4'b0010);
        chk("ws_m1_cs", s_cs, 6'h20);
        chk("ws_m1_rdy", bus_rdy, 0);

        // Reset while m1 is in WAIT, then a fresh m0 read to slave 1
        cyc();
        rest = 1'b1;
        settle();
        chk("rw_cs_wait", s_cs, 6'h20);
        cyc();
        rest = 1'b0;
        set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
        set_m(0, 1'b1, 1'b1, 1'b1, mk_addr(1), '0);
        s_rdy = 6'h02;
        settle();
        chk("rw_grnt", m_grnt, 0);
        chk("rw_cs", s_cs, 0);
        chk("rw_rdy", bus_rdy, 0);
        chk("rw_err", bus_err, 0);
        cyc(); settle();
        chk("rw_new_grnt", m_grnt, 4'b0001);
        chk("rw_new_cs", s_cs, 6'h02);
        chk("rw_new_rdy", bus_rdy, 1);
        chk("rw_new_data", bus_rd_data, 32'hA5A5_0001);

        set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
        s_rdy = '0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
